// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time branch predictions. On EX resolution it trains
// the predictor tables, flags mispredicts, and drains wrong-path fetches.
module branch_resolve_queue #(
  parameter int DEPTH       = 4,
  parameter int IDX_W       = 5,
  parameter int RECOVER_CYC = 2
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   push,
  input  logic                   push_pred_taken,
  input  logic [31:0]            push_pred_addr,
  input  logic [31:0]            push_fallthru,
  input  logic [IDX_W-1:0]       push_GHPT_index,
  input  logic [IDX_W-1:0]       push_GHR,
  input  logic [IDX_W-1:0]       push_BTB_index,
  input  logic                   resolve,
  input  logic                   actual_taken,
  input  logic [31:0]            actual_target,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   mispredict,
  output logic [31:0]            redirect_PC,
  output logic                   update_valid,
  output logic                   update_taken,
  output logic [IDX_W-1:0]       update_GHPT_index,
  output logic [IDX_W-1:0]       update_GHR,
  output logic [IDX_W-1:0]       update_BTB_index,
  output logic [31:0]            update_target,
  output logic [IDX_W-1:0]       restore_GHR,
  output logic                   recovering,
  output logic                   overflow,
  output logic                   underflow,
  output logic [15:0]            branch_count,
  output logic [15:0]            mispredict_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  typedef struct packed {
    logic             pred_taken;
    logic [31:0]      pred_addr;
    logic [31:0]      fallthru;
    logic [IDX_W-1:0] ghpt_idx;
    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] btb_idx;
  } entry_t;

  typedef enum logic {NORMAL, RECOVER} state_t;

  state_t          state, state_nxt;
  logic [RW-1:0]   rec_cnt, rec_nxt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  entry_t          mem [DEPTH];
  entry_t          head, new_ent;
  logic            do_pop, do_push, mis;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign recovering = (state == RECOVER);
  assign head       = mem[rd_ptr];
  assign new_ent    = '{push_pred_taken, push_pred_addr, push_fallthru,
                        push_GHPT_index, push_GHR, push_BTB_index};

  // A taken branch with the right direction but a stale BTB target still redirects.
  assign do_pop  = resolve && !empty;
  assign mis     = do_pop && ((head.pred_taken != actual_taken) ||
                              (actual_taken && head.pred_addr != actual_target));
  assign do_push = push && (state == NORMAL) && (!full || do_pop) && !mis;

  always_comb begin
    state_nxt = state;
    rec_nxt   = rec_cnt;
    if (mis) begin
      state_nxt = RECOVER;
      rec_nxt   = RW'(RECOVER_CYC - 1);
    end else if (state == RECOVER) begin
      if (rec_cnt == '0) state_nxt = NORMAL;
      else               rec_nxt   = rec_cnt - RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= NORMAL;
      rec_cnt <= '0;
    end else begin
      state <= state_nxt;
      rec_cnt <= rec_nxt;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      mispredict        <= 1'b0;
      redirect_PC       <= '0;
      update_valid      <= 1'b0;
      update_taken      <= 1'b0;
      update_GHPT_index <= '0;
      update_GHR        <= '0;
      update_BTB_index  <= '0;
      update_target     <= '0;
      restore_GHR       <= '0;
      overflow          <= 1'b0;
      underflow         <= 1'b0;
      branch_count      <= '0;
      mispredict_count  <= '0;
    end else begin
      update_valid <= do_pop;
      mispredict   <= mis;
      if (mis) begin
        // Everything behind the head was fetched down the wrong path.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        unique case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
      if (do_pop) begin
        update_taken      <= actual_taken;
        update_GHPT_index <= head.ghpt_idx;
        update_GHR        <= head.ghr;
        update_BTB_index  <= head.btb_idx;
        update_target     <= actual_target;
        if (branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
      end
      if (mis) begin
        redirect_PC <= actual_taken ? actual_target : head.fallthru;
        restore_GHR <= {head.ghr[IDX_W-2:0], actual_taken};
        if (mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
      end
      if (push && state == NORMAL && full && !do_pop) overflow <= 1'b1;
      if (resolve && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the branch resolve queue.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4, IDX_W = 5, RECOVER_CYC = 2;

  logic        clk = 1'b0, Reset = 1'b0;
  logic        push = 0, push_pred_taken = 0;
  logic [31:0] push_pred_addr = 0, push_fallthru = 0;
  logic [4:0]  push_GHPT_index = 0, push_GHR = 0, push_BTB_index = 0;
  logic        resolve = 0, actual_taken = 0;
  logic [31:0] actual_target = 0;
  logic        full, empty, mispredict, update_valid, update_taken, recovering, overflow, underflow;
  logic [2:0]  count;
  logic [31:0] redirect_PC, update_target;
  logic [4:0]  update_GHPT_index, update_GHR, update_BTB_index, restore_GHR;
  logic [15:0] branch_count, mispredict_count;

  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RECOVER_CYC(RECOVER_CYC)) dut (
    .clk(clk), .Reset(Reset), .push(push), .push_pred_taken(push_pred_taken),
    .push_pred_addr(push_pred_addr), .push_fallthru(push_fallthru),
    .push_GHPT_index(push_GHPT_index), .push_GHR(push_GHR), .push_BTB_index(push_BTB_index),
    .resolve(resolve), .actual_taken(actual_taken), .actual_target(actual_target),
    .full(full), .empty(empty), .count(count), .mispredict(mispredict),
    .redirect_PC(redirect_PC), .update_valid(update_valid), .update_taken(update_taken),
    .update_GHPT_index(update_GHPT_index), .update_GHR(update_GHR),
    .update_BTB_index(update_BTB_index), .update_target(update_target),
    .restore_GHR(restore_GHR), .recovering(recovering), .overflow(overflow),
    .underflow(underflow), .branch_count(branch_count), .mispredict_count(mispredict_count));

  always #5 clk = ~clk;

  typedef struct { logic pt; logic [31:0] pa, pf; logic [4:0] gi, gh, bi; } ent_t;
  ent_t        mq[$];
  int          m_rec, m_bc, m_mc;
  bit          m_of, m_uf, e_uv, e_mis, e_ut;
  logic [4:0]  e_gi, e_gh, e_bi, e_rg;
  logic [31:0] e_tg, e_rpc;
  int          n_cmp = 0, n_err = 0;

  function automatic void model_reset();
    mq.delete();
    m_rec = 0; m_bc = 0; m_mc = 0; m_of = 0; m_uf = 0; e_uv = 0; e_mis = 0;
  endfunction

  // Reference rules applied to the inputs currently being driven.
  function automatic void model_step();
    ent_t h;
    bit pop, mis, acc, blocked;
    h = '{0, 0, 0, 0, 0, 0};
    blocked = (m_rec > 0);
    pop = resolve && mq.size() > 0;
    mis = 0;
    if (pop) begin
      h = mq[0];
      mis = (h.pt != actual_taken) || (actual_taken && h.pa != actual_target);
    end
    if (resolve && mq.size() == 0) m_uf = 1;
    acc = push && !blocked && !mis && (mq.size() < DEPTH || pop);
    if (push && !blocked && mq.size() == DEPTH && !pop) m_of = 1;
    e_uv = pop; e_mis = mis;
    if (pop) begin
      e_ut = actual_taken; e_gi = h.gi; e_gh = h.gh; e_bi = h.bi; e_tg = actual_target;
      if (m_bc < 65535) m_bc++;
    end
    if (mis) begin
      e_rpc = actual_taken ? actual_target : h.pf;
      e_rg  = 5'((int'(h.gh) * 2 + int'(actual_taken)) % 32);
      if (m_mc < 65535) m_mc++;
      mq.delete();
      m_rec = RECOVER_CYC;
    end else begin
      if (blocked) m_rec--;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{push_pred_taken, push_pred_addr, push_fallthru,
                              push_GHPT_index, push_GHR, push_BTB_index});
    end
  endfunction

  task automatic cycle(input bit p, input bit pt, input logic [31:0] pa, input logic [31:0] pf,
                       input logic [4:0] gi, input logic [4:0] gh, input logic [4:0] bi,
                       input bit r, input bit at, input logic [31:0] tg);
    push = p; push_pred_taken = pt; push_pred_addr = pa; push_fallthru = pf;
    push_GHPT_index = gi; push_GHR = gh; push_BTB_index = bi;
    resolve = r; actual_taken = at; actual_target = tg;
    model_step();
    @(posedge clk); #1;
    push = 0; resolve = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 0; push = 0; resolve = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); Reset = 1;
  endtask

  task automatic test_reset();
    Reset = 0; #12;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (count !== 3'd0 || full !== 1'b0) begin n_err++; $display("FAIL reset_count got=%0d full=%b exp=0", count, full); end
    n_cmp++; if ({mispredict, update_valid, recovering, overflow, underflow} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got=%b exp=00000", {mispredict, update_valid, recovering, overflow, underflow}); end
    n_cmp++; if ({redirect_PC, update_target, restore_GHR, update_GHPT_index, update_GHR, update_BTB_index, update_taken} !== '0) begin
      n_err++; $display("FAIL reset_data got=%h/%h exp=0", redirect_PC, update_target); end
    n_cmp++; if ({branch_count, mispredict_count} !== 32'd0) begin
      n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
    do_reset();
  endtask

  task automatic test_correct_path();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h40, 32'h100 + 4 * i, 5'(i + 1), 5'(i), 5'(i + 2), 0, 0, 0);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL cp_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40);
      n_cmp++; if (update_valid !== 1'b1 || mispredict !== 1'b0) begin
        n_err++; $display("FAIL cp_pulse%0d got uv=%b mis=%b exp uv=1 mis=0", i, update_valid, mispredict); end
      n_cmp++; if (update_GHPT_index !== 5'(i + 1) || update_GHR !== 5'(i) || update_BTB_index !== 5'(i + 2)) begin
        n_err++; $display("FAIL cp_fields%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                          update_GHPT_index, update_GHR, update_BTB_index, i + 1, i, i + 2); end
    end
    n_cmp++; if (branch_count !== 16'd3 || empty !== 1'b1) begin
      n_err++; $display("FAIL cp_final got bc=%0d empty=%b exp bc=3 empty=1", branch_count, empty); end
    idle(1);
    n_cmp++; if (update_valid !== 1'b0) begin n_err++; $display("FAIL cp_pulse_end got=%b exp=0", update_valid); end
  endtask

  task automatic test_mispredict();
    do_reset();
    cycle(1, 0, 32'h0, 32'h104, 5'd3, 5'b01011, 5'd7, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h200);
    n_cmp++; if (mispredict !== 1'b1 || redirect_PC !== 32'h200) begin
      n_err++; $display("FAIL mp_redirect got mis=%b pc=%h exp mis=1 pc=200", mispredict, redirect_PC); end
    n_cmp++; if (restore_GHR !== 5'b10111) begin n_err++; $display("FAIL mp_restore got=%b exp=10111", restore_GHR); end
    n_cmp++; if (mispredict_count !== 16'd1 || update_target !== 32'h200 || update_taken !== 1'b1) begin
      n_err++; $display("FAIL mp_counts got mc=%0d tgt=%h ut=%b exp 1/200/1", mispredict_count, update_target, update_taken); end
    idle(1);
    n_cmp++; if (mispredict !== 1'b0 || recovering !== 1'b1) begin
      n_err++; $display("FAIL mp_after got mis=%b rec=%b exp mis=0 rec=1", mispredict, recovering); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'h40, 0, 5'(10 + i), 0, 0, 0, 0, 0);
    n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL of_full got full=%b of=%b exp 1/0", full, overflow); end
    cycle(1, 1, 32'h40, 0, 5'd20, 0, 0, 0, 0, 0);
    n_cmp++; if (overflow !== 1'b1 || count !== 3'd4) begin
      n_err++; $display("FAIL of_drop got of=%b cnt=%0d exp 1/4", overflow, count); end
    cycle(1, 1, 32'h40, 0, 5'd21, 0, 0, 1, 1, 32'h40);
    n_cmp++; if (count !== 3'd4 || update_valid !== 1'b1 || update_GHPT_index !== 5'd10) begin
      n_err++; $display("FAIL of_pushpop got cnt=%0d uv=%b gi=%0d exp 4/1/10", count, update_valid, update_GHPT_index); end
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40);
    n_cmp++; if (update_GHPT_index !== 5'd11 || count !== 3'd3) begin
      n_err++; $display("FAIL of_head got gi=%0d cnt=%0d exp 11/3", update_GHPT_index, count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'h80, 0, 5'(i), 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h80, 0, 5'd9, 0, 0, 1, 1, 32'h90);
    n_cmp++; if (mispredict !== 1'b1 || redirect_PC !== 32'h90 || count !== 3'd0 || recovering !== 1'b1) begin
      n_err++; $display("FAIL fl_flush got mis=%b pc=%h cnt=%0d rec=%b exp 1/90/0/1", mispredict, redirect_PC, count, recovering); end
    cycle(1, 1, 32'h80, 0, 5'd9, 0, 0, 0, 0, 0);
    n_cmp++; if (recovering !== 1'b1 || count !== 3'd0) begin
      n_err++; $display("FAIL fl_rec1 got rec=%b cnt=%0d exp 1/0", recovering, count); end
    cycle(1, 1, 32'h80, 0, 5'd9, 0, 0, 0, 0, 0);
    n_cmp++; if (recovering !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL fl_rec2 got rec=%b cnt=%0d exp 0/0", recovering, count); end
    cycle(1, 1, 32'h80, 0, 5'd9, 0, 0, 0, 0, 0);
    n_cmp++; if (count !== 3'd1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL fl_accept got cnt=%0d of=%b exp 1/0", count, overflow); end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40);
    n_cmp++; if (update_valid !== 1'b0 || mispredict !== 1'b0 || underflow !== 1'b1 || branch_count !== 16'd0) begin
      n_err++; $display("FAIL uf_empty got uv=%b mis=%b uf=%b bc=%0d exp 0/0/1/0", update_valid, mispredict, underflow, branch_count); end
    cycle(1, 1, 32'h40, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h40, 0, 2, 0, 0, 1, 1, 32'h40);
    #2 Reset = 0; #1;
    n_cmp++; if (empty !== 1'b1 || count !== 3'd0 || underflow !== 1'b0 || update_valid !== 1'b0 || branch_count !== 16'd0) begin
      n_err++; $display("FAIL uf_midreset got empty=%b cnt=%0d uf=%b uv=%b bc=%0d exp 1/0/0/0/0",
                        empty, count, underflow, update_valid, branch_count); end
    model_reset();
    @(negedge clk); Reset = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      cycle($urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)),
            $urandom_range(0, 1) ? 32'h40 : 32'h80, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
            $urandom_range(0, 99) < 45, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0 ? 32'h40 : 32'h80);
      n_cmp++; if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) || recovering !== (m_rec > 0)) begin
        n_err++; $display("FAIL rnd_status c=%0d got cnt=%0d rec=%b exp cnt=%0d rec=%0d", c, count, recovering, mq.size(), m_rec); end
      n_cmp++; if (update_valid !== e_uv || mispredict !== e_mis) begin
        n_err++; $display("FAIL rnd_pulse c=%0d got uv=%b mis=%b exp %b/%b", c, update_valid, mispredict, e_uv, e_mis); end
      if (e_uv) begin
        n_cmp++; if ({update_taken, update_GHPT_index, update_GHR, update_BTB_index, update_target} !== {e_ut, e_gi, e_gh, e_bi, e_tg}) begin
          n_err++; $display("FAIL rnd_update c=%0d got %b/%0d/%0d/%0d/%h exp %b/%0d/%0d/%0d/%h", c, update_taken,
                            update_GHPT_index, update_GHR, update_BTB_index, update_target, e_ut, e_gi, e_gh, e_bi, e_tg); end
      end
      if (e_mis) begin
        n_cmp++; if (redirect_PC !== e_rpc || restore_GHR !== e_rg) begin
          n_err++; $display("FAIL rnd_redirect c=%0d got %h/%b exp %h/%b", c, redirect_PC, restore_GHR, e_rpc, e_rg); end
      end
      n_cmp++; if ({overflow, underflow} !== {m_of, m_uf} || branch_count !== 16'(m_bc) || mispredict_count !== 16'(m_mc)) begin
        n_err++; $display("FAIL rnd_stats c=%0d got of=%b uf=%b bc=%0d mc=%0d exp %b/%b/%0d/%0d", c,
                          overflow, underflow, branch_count, mispredict_count, m_of, m_uf, m_bc, m_mc); end
    end
  endtask

  initial begin
    test_reset();
    test_correct_path();
    test_mispredict();
    test_overflow();
    test_flush();
    test_underflow_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Back end of the branch prediction path: holds every fetch-time prediction from the tournament predictor until the branch resolves in EX.
- On resolution it compares the prediction with the actual outcome and raises a mispredict redirect.
- It drives the predictor-table update signals (GHPT/BTB index, GHR snapshot, target) and a repaired GHR.
- It sits between the IF/ID predictor interface and the EX branch unit.

Parameters:
- DEPTH, 4, number of in-flight predicted branches held (power of 2, at least 2).
- IDX_W, 5, width of the GHPT index, BTB index and GHR.
- RECOVER_CYC, 2, cycles pushes are suppressed after a mispredict (wrong-path drain).

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; state clears while Reset==0.
- push  in  1  a branch leaves fetch with a prediction; enqueue this cycle.
- push_pred_taken  in  1  predicted direction.
- push_pred_addr  in  32  predicted next PC.
- push_fallthru  in  32  PC+4 of the branch (nextPC).
- push_GHPT_index  in  IDX_W  GHPT index used at fetch.
- push_GHR  in  IDX_W  GHR snapshot before speculative update.
- push_BTB_index  in  IDX_W  BTB index used at fetch.
- resolve  in  1  the oldest branch resolves in EX (Branch_EX).
- actual_taken  in  1  resolved direction.
- actual_target  in  32  resolved taken target.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  $clog2(DEPTH)+1  occupancy.
- mispredict  out  1  registered one-cycle pulse.
- redirect_PC  out  32  correct PC; valid with mispredict.
- update_valid  out  1  registered one-cycle pulse per resolved branch.
- update_taken  out  1  actual direction for PHT training.
- update_GHPT_index  out  IDX_W  index to train.
- update_GHR  out  IDX_W  stored snapshot (GHR_in to predictor).
- update_BTB_index  out  IDX_W  BTB entry to write.
- update_target  out  32  actual_target for BTB write.
- restore_GHR  out  IDX_W  {snapshot[IDX_W-2:0], actual_taken}; valid with mispredict.
- recovering  out  1  high while in RECOVER.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a resolve occurred while empty.
- branch_count  out  16  resolved branches, saturating.
- mispredict_count  out  16  mispredicts, saturating.

Behaviour:
- Reset (async, Reset==0): queue empty, pointers 0, state NORMAL. All outputs 0 except empty=1.
- Queue is a circular FIFO with wrap-around read/write pointers. Entries are stored in program order. Resolve always refers to the head entry.
- Push accepted when state==NORMAL and !full and no mispredict is detected this cycle.
  - Push while full: dropped, overflow set.
  - Push in RECOVER: dropped silently.
- Resolve with !empty pops the head.
  - mis = (pred_taken != actual_taken) OR (actual_taken AND pred_addr != actual_target).
  - One cycle later: update_valid=1, update_* from the head entry, update_taken=actual_taken, update_target=actual_target.
  - One cycle later, if mis: mispredict=1, redirect_PC = actual_taken ? actual_target : fallthru, restore_GHR as defined.
  - Resolve when empty: ignored, no pulses, underflow set.
- Simultaneous push and resolve, no mis: both happen and count is unchanged; legal when full.
- Mispredict flush: the whole queue is cleared (all younger entries are wrong path), a same-cycle push is discarded, state goes to RECOVER, and the recover counter loads RECOVER_CYC-1.
- RECOVER: counter decrements each cycle; on reaching 0 the state returns to NORMAL the next cycle, so pushes are blocked for exactly RECOVER_CYC cycles. A resolve during RECOVER sets underflow because the queue is empty.
- Counters: branch_count +1 per valid resolve, mispredict_count +1 per mis. Both saturate at 16'hFFFF.
- Reset mid-operation: immediate clear, including sticky flags and counters.

Test Plan:
- Push 3 branches (pred_taken=1, pred_addr=0x40), then resolve 3 with taken/0x40 -> 3 update_valid pulses one cycle after each resolve, mispredict stays 0, branch_count=3, empty=1.
- Push pred_taken=0 with fallthru=0x104 and GHR=5'b01011, resolve taken with target 0x200 -> next cycle mispredict=1, redirect_PC=0x200, restore_GHR=5'b10111, mispredict_count=1.
- Push 4 (full=1), push a 5th -> overflow=1 and count stays 4. Then push+resolve in the same cycle with a correct prediction -> count stays 4 and the head advances.
- Push 3 with the head mispredicted (pred_addr 0x80, actual 0x90), push in the same cycle and for 2 cycles after -> queue empty, recovering high for 2 cycles, all those pushes dropped, a push on cycle 3 is accepted (count=1).
- Resolve on an empty queue -> no pulses, underflow=1. Then assert Reset=0 mid-queue -> all outputs 0, empty=1, underflow cleared.
